// File: rtl/if_fetch_queue_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : if_fetch_queue_pkg                                            |
// | Brief   : Shared constants, entry layout and AdEL check for fetch queue |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
package if_fetch_queue_pkg;

  localparam logic [31:0] C_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] C_IM_BASE  = 32'h0000_3000;
  localparam int unsigned C_IM_BYTES = 16384;
  localparam logic [31:0] C_NOP      = 32'h0000_0000;

  typedef struct packed {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // The limit is carried in 33 bits so a window ending at 4 GiB cannot wrap.
  function automatic logic fetch_adel(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [32:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_fetch_queue_fq_store.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : fq_store                                                      |
// | Brief   : DEPTH x {adel, pc, instr} array, one write port, async read   |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
module fq_store
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  // No reset: contents are only observed through the valid-gated head mux.
  fq_entry_t r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : if_fetch_queue                                                |
// | Brief   : IF->ID fetch queue with back-pressure, AdEL tagging and flush |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2,
  parameter logic [31:0] RESET_PC = C_RESET_PC,
  parameter logic [31:0] IM_BASE  = C_IM_BASE,
  parameter int unsigned IM_BYTES = C_IM_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_instr,
  input  logic          flush,
  input  logic          id_ready,
  output logic          pc_en,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_instr,
  output logic          id_exc_adel,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   C_FULL     = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
  localparam logic [AW:0]   C_CNT_ONE  = (AW + 1)'(1);
  localparam logic [32:0]   C_IM_LIMIT = {1'b0, IM_BASE} + 33'(IM_BYTES);

  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic          w_full;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_adel;
  fq_entry_t     w_wdata;
  fq_entry_t     w_head;

  assign w_full  = (r_count == C_FULL);
  assign w_valid = (r_count != '0);

  // pc_en looks only at registered occupancy so id_ready never reaches the PC.
  assign pc_en  = ~w_full | flush;
  assign w_push = pc_en & ~flush;
  assign w_pop  = w_valid & id_ready & ~flush;

  assign w_adel        = fetch_adel(if_pc, IM_BASE, C_IM_LIMIT);
  assign w_wdata.adel  = w_adel;
  assign w_wdata.pc    = if_pc;
  assign w_wdata.instr = w_adel ? C_NOP : if_instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  fq_store #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .clk   (clk),
    .we    (w_push),
    .waddr (r_wr_ptr),
    .wdata (w_wdata),
    .raddr (r_rd_ptr),
    .rdata (w_head)
  );

  assign id_valid    = w_valid;
  assign id_pc       = w_valid ? w_head.pc    : RESET_PC;
  assign id_instr    = w_valid ? w_head.instr : C_NOP;
  assign id_exc_adel = w_valid ? w_head.adel  : 1'b0;
  assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | Module  : tb_if_fetch_queue                                             |
// | Brief   : Scoreboard bench for if_fetch_queue with an IM/PC model       |
// | Revision: 1.0 - initial release                                         |
// +-------------------------------------------------------------------------+
module tb_if_fetch_queue;

  localparam logic [31:0] C_RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        id_ready;
  logic        pc_en;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_exc_adel;
  logic [2:0]  count;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .id_ready    (id_ready),
    .pc_en       (pc_en),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_exc_adel (id_exc_adel),
    .count       (count)
  );

  typedef struct {
    logic        adel;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] pc;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Legal window is [0x3000, 0x7000), word aligned.
  function automatic logic exp_adel(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic fl);
    int sz;
    sz = sb.size();
    if (sz == 0) begin
      chk("id_valid", 32'(id_valid), 32'd0);
      chk("id_pc", id_pc, C_RST_PC);
      chk("id_instr", id_instr, 32'd0);
      chk("id_exc_adel", 32'(id_exc_adel), 32'd0);
    end else begin
      chk("id_valid", 32'(id_valid), 32'd1);
      chk("id_pc", id_pc, sb[0].pc);
      chk("id_instr", id_instr, sb[0].instr);
      chk("id_exc_adel", 32'(id_exc_adel), 32'(sb[0].adel));
    end
    chk("count", 32'(count), 32'(sz));
    chk("pc_en", 32'(pc_en), 32'((sz != 4) || fl));
  endtask

  // One clock of IF/ID activity; the bench plays the PC register and IM.
  task automatic cycle(input logic fl, input logic rdy, input logic [31:0] tgt);
    int   sz;
    ent_t e;
    flush    = fl;
    id_ready = rdy;
    if_pc    = pc;
    if_instr = imem(pc);
    #1;
    check_outputs(fl);
    sz = sb.size();
    @(posedge clk);
    if (fl) begin
      sb.delete();
      pc = tgt;
    end else begin
      if (rdy && sz > 0) void'(sb.pop_front());
      if (sz != 4) begin
        e.adel  = exp_adel(pc);
        e.pc    = pc;
        e.instr = e.adel ? 32'd0 : imem(pc);
        sb.push_back(e);
        pc = pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  logic [31:0] adel_list [6];

  initial begin
    reset    = 1'b1;
    flush    = 1'b0;
    id_ready = 1'b0;
    if_pc    = C_RST_PC;
    if_instr = 32'd0;
    pc       = C_RST_PC;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outputs(1'b0);
    reset = 1'b0;

    // Streaming with decode always ready: occupancy settles at one.
    repeat (4) cycle(1'b0, 1'b1, 32'd0);

    // Stall decode until full, then a single pop at full.
    repeat (6) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'd0);

    // Redirect with three entries queued.
    cycle(1'b1, 1'b1, 32'h0000_3400);
    cycle(1'b0, 1'b1, 32'd0);
    cycle(1'b0, 1'b1, 32'd0);

    // Fill, then drain in order.
    repeat (5) cycle(1'b0, 1'b0, 32'd0);
    repeat (6) cycle(1'b0, 1'b1, 32'd0);

    // Address-error boundaries.
    adel_list[0] = 32'h0000_3002;
    adel_list[1] = 32'h0000_2FFC;
    adel_list[2] = 32'h0000_7000;
    adel_list[3] = 32'h0000_3FFC;
    adel_list[4] = 32'h0000_6FFC;
    adel_list[5] = 32'h0000_3000;
    for (int i = 0; i < 6; i++) begin
      pc = adel_list[i];
      cycle(1'b0, 1'b1, 32'd0);
    end
    repeat (2) cycle(1'b0, 1'b1, 32'd0);

    // Reset together with flush while two entries are queued.
    cycle(1'b1, 1'b0, 32'h0000_5000);
    repeat (2) cycle(1'b0, 1'b0, 32'd0);
    #1;
    check_outputs(1'b0);
    reset    = 1'b1;
    flush    = 1'b1;
    id_ready = 1'b1;
    @(posedge clk);
    sb.delete();
    pc = C_RST_PC;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle(1'b0, 1'b1, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
